// File: rtl/if_stage_if.sv
// Instruction-memory request/response channel between the fetch stage (master)
// and instruction memory (slave).
interface if_stage_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  mem_req;
  logic [WORD_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [WORD_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches, absorbs memory latency,
// decode stalls and execute redirects, and feeds the IF pipeline register.
//
// state | meaning
// FETCH | request outstanding at pc; waiting for mem_ack
// HOLD  | fetched word parked in hold_* while decode is frozen; no memory traffic
module if_stage #(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_addr,
  if_stage_if.master            bus,
  output logic [WORD_WIDTH-1:0] pc_out,
  output logic [WORD_WIDTH-1:0] instruction_out,
  output logic                  fetch_stall
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                state, state_n;
  logic [WORD_WIDTH-1:0] pc, pc_n;
  logic [WORD_WIDTH-1:0] hold_instr, hold_instr_n;
  logic [WORD_WIDTH-1:0] hold_pc4, hold_pc4_n;
  logic                  redirect_pend, redirect_pend_n;
  logic [WORD_WIDTH-1:0] redirect_addr, redirect_addr_n;

  logic [WORD_WIDTH-1:0] pc4;
  logic [WORD_WIDTH-1:0] branch_aligned;
  logic [WORD_WIDTH-1:0] reset_pc_aligned;
  logic                  req_c;
  logic                  stall_c;
  logic [WORD_WIDTH-1:0] instr_c;
  logic [WORD_WIDTH-1:0] pc_out_c;
  logic                  unused_branch_lsbs;

  assign pc4                = pc + WORD_WIDTH'(4);
  assign branch_aligned     = {branch_addr[WORD_WIDTH-1:2], 2'b00};
  assign reset_pc_aligned   = {RESET_PC[WORD_WIDTH-1:2], 2'b00};
  assign unused_branch_lsbs = ^branch_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= reset_pc_aligned;
      hold_instr    <= '0;
      hold_pc4      <= '0;
      redirect_pend <= 1'b0;
      redirect_addr <= '0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      hold_instr    <= hold_instr_n;
      hold_pc4      <= hold_pc4_n;
      redirect_pend <= redirect_pend_n;
      redirect_addr <= redirect_addr_n;
    end
  end

  always_comb begin
    state_n         = state;
    pc_n            = pc;
    hold_instr_n    = hold_instr;
    hold_pc4_n      = hold_pc4;
    redirect_pend_n = redirect_pend;
    redirect_addr_n = redirect_addr;
    req_c           = 1'b0;
    stall_c         = 1'b0;
    instr_c         = '0;
    pc_out_c        = '0;

    case (state)
      FETCH: begin
        req_c = 1'b1;
        if (!bus.mem_ack) begin
          // The request address must not move while outstanding, so a
          // redirect arriving now is parked until the response returns.
          stall_c = 1'b1;
          if (branch_taken) begin
            redirect_pend_n = 1'b1;
            redirect_addr_n = branch_aligned;
          end
        end else if (branch_taken) begin
          // A branch in the ack cycle is the newest redirect and wins.
          pc_n            = branch_aligned;
          redirect_pend_n = 1'b0;
        end else if (redirect_pend) begin
          pc_n            = redirect_addr;
          redirect_pend_n = 1'b0;
        end else begin
          instr_c  = bus.mem_rdata;
          pc_out_c = pc4;
          if (freeze) begin
            hold_instr_n = bus.mem_rdata;
            hold_pc4_n   = pc4;
            state_n      = HOLD;
          end else begin
            pc_n = pc4;
          end
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_n    = branch_aligned;
          state_n = FETCH;
        end else begin
          instr_c  = hold_instr;
          pc_out_c = hold_pc4;
          if (!freeze) begin
            pc_n    = pc4;
            state_n = FETCH;
          end
        end
      end

      default: state_n = FETCH;
    endcase
  end

  // Reset forces a quiet bus and a bubble into the IF register immediately.
  assign bus.mem_req     = req_c & ~rst;
  assign bus.mem_addr    = pc;
  assign fetch_stall     = stall_c & ~rst;
  assign instruction_out = rst ? '0 : instr_c;
  assign pc_out          = rst ? '0 : pc_out_c;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter WORD_WIDTH, default 32, data/address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value after reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 freeze  input  1  hazard stall from decode; holds fetch progress.
REQ-006 branch_taken  input  1  redirect request from execute; same cycle as IF register flush.
REQ-007 branch_addr  input  WORD_WIDTH  redirect target.
REQ-008 mem_req  output  1  instruction-memory request valid.
REQ-009 mem_addr  output  WORD_WIDTH  instruction-memory byte address.
REQ-010 mem_ack  input  1  memory response valid; may assert in the same cycle as mem_req.
REQ-011 mem_rdata  input  WORD_WIDTH  instruction word, valid only with mem_ack.
REQ-012 pc_out  output  WORD_WIDTH  fetched PC + 4, to IF register PC input.
REQ-013 instruction_out  output  WORD_WIDTH  fetched instruction, to IF register instruction input.
REQ-014 fetch_stall  output  1  fetch pending; ORed with freeze by the hazard unit.

Function
REQ-015 Internal regs: pc, state {FETCH, HOLD}, hold_instr, hold_pc4, redirect_pend, redirect_addr.
REQ-016 pc and redirect_addr SHALL always have bits [1:0] = 0; incoming branch_addr[1:0] ignored.
REQ-017 pc + 4 SHALL wrap modulo 2^WORD_WIDTH (32'hFFFF_FFFC -> 0).
REQ-018 FETCH: mem_req = 1, mem_addr = pc; mem_addr SHALL stay stable until mem_ack.
REQ-019 FETCH, mem_ack = 0: fetch_stall = 1, outputs = 0 (bubble); pc unchanged.
REQ-020 FETCH, mem_ack = 0, branch_taken = 1: set redirect_pend, capture redirect_addr; keep request unchanged.
REQ-021 FETCH, mem_ack = 1, redirect_pend = 1: outputs 0, response discarded, pc <= redirect_addr, clear redirect_pend, stay FETCH.
REQ-022 FETCH, mem_ack = 1, branch_taken = 1: outputs 0, pc <= branch_addr, stay FETCH (branch beats freeze).
REQ-023 FETCH, mem_ack = 1, no branch, freeze = 0: instruction_out = mem_rdata, pc_out = pc + 4 (same cycle), pc <= pc + 4, stay FETCH; fetch_stall = 0.
REQ-024 FETCH, mem_ack = 1, no branch, freeze = 1: same outputs as REQ-023; hold_instr <= mem_rdata, hold_pc4 <= pc + 4, pc unchanged, -> HOLD.
REQ-025 HOLD: mem_req = 0, fetch_stall = 0, instruction_out = hold_instr, pc_out = hold_pc4.
REQ-026 HOLD, branch_taken = 1: outputs 0, pc <= branch_addr, -> FETCH.
REQ-027 HOLD, freeze = 0, no branch: outputs hold values this cycle, pc <= pc + 4, -> FETCH.
REQ-028 HOLD, freeze = 1: remain HOLD, no memory traffic.
REQ-029 Throughput: one instruction per cycle when mem_ack is tied high and freeze = 0.

Reset
REQ-030 rst = 1 SHALL immediately set pc = RESET_PC, state = FETCH, redirect_pend = 0, hold_instr = 0, hold_pc4 = 0.
REQ-031 During rst, outputs SHALL be mem_req = 0, instruction_out = 0, pc_out = 0, fetch_stall = 0.
REQ-032 Reset mid-wait SHALL abandon the outstanding request; a late mem_ack after reset release returns data for RESET_PC, as the request is reissued.

Verification
REQ-033 mem_ack tied 1, rdata = addr ^ 32'hA5A5_0000, 4 cycles -> pc_out 4, 8, 12, 16 with matching instructions, fetch_stall never 1.
REQ-034 mem_ack delayed 3 cycles at pc = 8 -> mem_addr = 8 held, fetch_stall = 1 for 3 cycles, outputs 0, then pc_out = 12.
REQ-035 freeze = 1 for 2 cycles on ack at pc = 4 -> HOLD, outputs stay pc_out = 8 and same instruction, mem_req = 0, then resumes at mem_addr = 8.
REQ-036 branch_taken with branch_addr = 32'h0000_0103 during wait at pc = 12 -> next ack output 0, next mem_addr = 32'h0000_0100.
REQ-037 branch_taken and freeze together in HOLD -> outputs 0, mem_addr = branch_addr next cycle.
REQ-038 pc = 32'hFFFF_FFFC, ack -> pc_out = 0, next mem_addr = 0; rst asserted mid-wait -> mem_req = 0 immediately, mem_addr = RESET_PC after release.
